// File: rtl/spi_slave_ctrl_if.sv
// Bundle of the SPI serial pins and the command-RAM side of spi_slave_ctrl.
// The master modport is the bus/RAM side; the slave modport is the controller.
interface spi_slave_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises one command frame per ss_n window, forwards it
// to the command RAM and serialises read data back on miso.
module spi_slave_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input logic             clk,
  input logic             reset_n,
  spi_slave_ctrl_if.slave bus
);

  localparam int unsigned FRAME_W  = DATA_W + 2;
  localparam int unsigned CNT_W    = $clog2(FRAME_W + 1);
  localparam int unsigned TX_CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  shift_en;
  logic                  frame_end;
  logic                  tx_start;

  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_done;
  logic [FRAME_W-2:0]    shift_q;
  logic                  rd_addr_ok;

  logic [DATA_W-1:0]     tx_sr;
  logic [TX_CNT_W-1:0]   tx_cnt;

  logic                  miso_q;
  logic [FRAME_W-1:0]    rx_data_q;
  logic                  rx_valid_q;

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes; ss_n high always wins.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    tx_start  = 1'b0;
    if (bus.ss_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CHK_CMD;
        CHK_CMD: begin
          shift_en = 1'b1;
          if (!bus.mosi)      state_d = WRITE;
          else if (rd_addr_ok) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shift_en  = 1'b1;
            frame_end = (bit_cnt == CNT_W'(FRAME_W - 1));
          end
          // RAM answers combinationally in the rx_valid cycle only.
          tx_start = (state_q == READ_DATA) && rx_valid_q && bus.tx_valid;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receive path: frame shifter, completed-frame register and read-address flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_addr_ok <= 1'b0;
    end else begin
      rx_valid_q <= frame_end;
      if (bus.ss_n || state_q == IDLE) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_W-3:0], bus.mosi};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (frame_end) frame_done <= 1'b1;
      end
      if (frame_end) begin
        rx_data_q <= {shift_q, bus.mosi};
        if (state_q == READ_ADD)       rd_addr_ok <= 1'b1;
        else if (state_q == READ_DATA) rd_addr_ok <= 1'b0;
      end
    end
  end

  // Transmit path: MSB-first serialiser, cut short whenever ss_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_q <= 1'b0;
      tx_sr  <= '0;
      tx_cnt <= '0;
    end else if (bus.ss_n) begin
      miso_q <= 1'b0;
      tx_cnt <= '0;
    end else if (tx_start) begin
      miso_q <= bus.tx_data[DATA_W-1];
      tx_sr  <= {bus.tx_data[DATA_W-2:0], 1'b0};
      tx_cnt <= TX_CNT_W'(DATA_W - 1);
    end else if (tx_cnt != '0) begin
      miso_q <= tx_sr[DATA_W-1];
      tx_sr  <= tx_sr << 1;
      tx_cnt <= tx_cnt - TX_CNT_W'(1);
    end else begin
      miso_q <= 1'b0;
    end
  end

endmodule
